// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- one memory request/response port.
// The requester drives valid/instr/addr/wdata/wstrb.
// The responder returns rdata and a one-cycle ready pulse.
// The master modport is the requester side; the slave modport is the responder side.
interface mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (output valid, instr, addr, wdata, wstrb, input  rdata, ready);
    modport slave  (input  valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between an instruction-fetch port and a data port.
// Each port holds one pending request.
// At most one memory transaction is outstanding at a time.
// Optional macro ARB_ROUND_ROBIN_EN: when both ports contend, grant the port that was not granted last.
// With the macro undefined, the data port always wins a conflict.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  imem,
    mem_arbiter_if.slave  dmem,
    mem_arbiter_if.master mem
);
    typedef enum logic [1:0] { IDLE, WAIT_I, WAIT_D } state_t;

    state_t      state;

    logic        i_pend, d_pend;
    logic        i_instr_q, d_instr_q;
    logic [31:0] i_addr_q, d_addr_q;
    logic [31:0] i_wdata_q, d_wdata_q;
    logic [3:0]  i_wstrb_q, d_wstrb_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_grant_d;
`endif

    logic        i_req, d_req;
    logic        grant_d;
    logic        issue, issue_d;
    logic        sel_instr;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wstrb;

    // A port wants the memory if it already holds a request or one is arriving now
    always_comb begin
        i_req = i_pend | imem.valid;
        d_req = d_pend | dmem.valid;
    end

    // Conflict policy used when a grant is decided from IDLE
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_d = ~last_grant_d;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
    end

    // Decide whether a new memory request goes out at the next edge and for which port
    always_comb begin
        issue   = 1'b0;
        issue_d = 1'b0;
        case (state)
            IDLE: begin
                issue   = i_req | d_req;
                issue_d = grant_d;
            end
            WAIT_I: begin
                issue   = mem.ready & d_req;
                issue_d = 1'b1;
            end
            WAIT_D: begin
                issue   = mem.ready & i_req;
                issue_d = 1'b0;
            end
            default: begin
                issue   = 1'b0;
                issue_d = 1'b0;
            end
        endcase
    end

    // Fields of the granted port: the stored copy if pending, else the live inputs
    always_comb begin
        if (issue_d) begin
            sel_instr = d_pend ? d_instr_q : dmem.instr;
            sel_addr  = d_pend ? d_addr_q  : dmem.addr;
            sel_wdata = d_pend ? d_wdata_q : dmem.wdata;
            sel_wstrb = d_pend ? d_wstrb_q : dmem.wstrb;
        end else begin
            sel_instr = i_pend ? i_instr_q : imem.instr;
            sel_addr  = i_pend ? i_addr_q  : imem.addr;
            sel_wdata = i_pend ? i_wdata_q : imem.wdata;
            sel_wstrb = i_pend ? i_wstrb_q : imem.wstrb;
        end
    end

    // Arbiter FSM, per-port pending registers and the registered memory-side request
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i_pend    <= 1'b0;
            d_pend    <= 1'b0;
            i_instr_q <= 1'b0;
            d_instr_q <= 1'b0;
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            i_wdata_q <= '0;
            d_wdata_q <= '0;
            i_wstrb_q <= '0;
            d_wstrb_q <= '0;
            mem.valid <= 1'b0;
            mem.instr <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            mem.wstrb <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b1;
`endif
        end else begin
            mem.valid <= issue;
            if (issue) begin
                mem.instr <= sel_instr;
                mem.addr  <= sel_addr;
                mem.wdata <= sel_wdata;
                mem.wstrb <= sel_wstrb;
                state     <= issue_d ? WAIT_D : WAIT_I;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_d <= issue_d;
`endif
            end else if (state != IDLE && mem.ready) begin
                state <= IDLE;
            end

            if (state == WAIT_I && mem.ready) begin
                i_pend <= 1'b0;
            end else if (!i_pend && imem.valid) begin
                i_pend    <= 1'b1;
                i_instr_q <= imem.instr;
                i_addr_q  <= imem.addr;
                i_wdata_q <= imem.wdata;
                i_wstrb_q <= imem.wstrb;
            end

            if (state == WAIT_D && mem.ready) begin
                d_pend <= 1'b0;
            end else if (!d_pend && dmem.valid) begin
                d_pend    <= 1'b1;
                d_instr_q <= dmem.instr;
                d_addr_q  <= dmem.addr;
                d_wdata_q <= dmem.wdata;
                d_wstrb_q <= dmem.wstrb;
            end
        end
    end

    // Completion steering: only the port that owns the outstanding transaction sees ready
    assign imem.ready = mem.ready & (state == WAIT_I) & ~rst;
    assign dmem.ready = mem.ready & (state == WAIT_D) & ~rst;
    assign imem.rdata = mem.rdata;
    assign dmem.rdata = mem.rdata;
endmodule
